// File: rtl/tictactoe_turn_ctrl.sv
// Turn sequencer and move arbiter in front of the tictactoe core (board state lives in the core).
// Optional human-turn forfeit timer: define TURN_TIMEOUT_EN.
module tictactoe_turn_ctrl #(
    parameter int CORE_LAT    = 1,
    parameter int SCORE_W     = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               ai_x,
    input  logic               ai_o,
    input  logic               x_req,
    input  logic [1:0]         x_row,
    input  logic [1:0]         x_col,
    input  logic               o_req,
    input  logic [1:0]         o_row,
    input  logic [1:0]         o_col,
    output logic               x_ack,
    output logic               x_nack,
    output logic               o_ack,
    output logic               o_nack,
    output logic               core_clr,
    output logic               core_go,
    output logic [1:0]         core_xoro,
    output logic [1:0]         core_row,
    output logic [1:0]         core_col,
    output logic               core_ai_en,
    input  logic               core_err,
    input  logic [1:0]         core_win,
    input  logic [1:0]         core_rowout,
    input  logic [1:0]         core_colout,
    output logic [1:0]         turn,
    output logic [3:0]         move_cnt,
    output logic               game_over,
    output logic [1:0]         result,
    output logic [1:0]         last_row,
    output logic [1:0]         last_col,
    output logic [SCORE_W-1:0] x_score,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] draw_score,
    output logic               timeout
);

    if (CORE_LAT < 1 || CORE_LAT > 3 || SCORE_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("tictactoe_turn_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT, S_ISSUE, S_RESP, S_OVER
    } state_t;

    localparam logic [1:0] SIDE_NONE = 2'b00;
    localparam logic [1:0] SIDE_X    = 2'b01;
    localparam logic [1:0] SIDE_O    = 2'b10;
    localparam logic [1:0] RES_DRAW  = 2'b11;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t     state, nxt_state;
    logic       x_req_d, o_req_d;
    logic       ai_x_q, ai_o_q;
    logic [1:0] lat_cnt;
    logic       x_edge, o_edge;
    logic       ai_turn, x_serve, o_serve, issue;
    logic       resp_done, end_game, timeout_hit;
    logic [1:0] opp, award;
    logic       x_ack_n, x_nack_n, o_ack_n, o_nack_n;

    assign x_edge    = x_req & ~x_req_d;
    assign o_edge    = o_req & ~o_req_d;
    assign opp       = {turn[0], turn[1]};
    assign ai_turn   = (turn == SIDE_X && ai_x_q) || (turn == SIDE_O && ai_o_q);
    assign x_serve   = state == S_WAIT && !new_game && turn == SIDE_X && !ai_x_q && x_edge
                       && x_row != 2'd3 && x_col != 2'd3;
    assign o_serve   = state == S_WAIT && !new_game && turn == SIDE_O && !ai_o_q && o_edge
                       && o_row != 2'd3 && o_col != 2'd3;
    assign issue     = state == S_WAIT && !new_game && (ai_turn || x_serve || o_serve);
    assign resp_done = state == S_RESP && lat_cnt == 2'(CORE_LAT - 1);
    assign core_clr  = state == S_CLEAR;
    assign core_go   = state == S_ISSUE;
    assign game_over = state == S_OVER;

    // Any request edge that is not taken as a move is refused, whatever the state.
    assign x_ack_n  = resp_done && !core_err && !core_ai_en && core_xoro == SIDE_X;
    assign o_ack_n  = resp_done && !core_err && !core_ai_en && core_xoro == SIDE_O;
    assign x_nack_n = (x_edge && !x_serve) || (resp_done && core_err && !core_ai_en && core_xoro == SIDE_X);
    assign o_nack_n = (o_edge && !o_serve) || (resp_done && core_err && !core_ai_en && core_xoro == SIDE_O);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        award    = SIDE_NONE;
        end_game = 1'b0;
        if (resp_done) begin
            if (core_err) begin
                if (core_ai_en) begin
                    award    = opp;
                    end_game = 1'b1;
                end
            end else if (core_win != SIDE_NONE) begin
                award    = core_win;
                end_game = 1'b1;
            end else if (move_cnt == 4'd8) begin
                award    = RES_DRAW;
                end_game = 1'b1;
            end
        end
        if (timeout_hit) begin
            award    = opp;
            end_game = 1'b1;
        end
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            S_IDLE, S_OVER: if (new_game) nxt_state = S_CLEAR;
            S_CLEAR:        nxt_state = S_WAIT;
            S_WAIT: begin
                if (new_game)         nxt_state = S_CLEAR;
                else if (issue)       nxt_state = S_ISSUE;
                else if (timeout_hit) nxt_state = S_OVER;
            end
            S_ISSUE:        nxt_state = S_RESP;
            S_RESP:         if (resp_done) nxt_state = end_game ? S_OVER : S_WAIT;
            default:        nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt_state;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_req_d    <= 1'b0;
            o_req_d    <= 1'b0;
            ai_x_q     <= 1'b0;
            ai_o_q     <= 1'b0;
            lat_cnt    <= '0;
            x_ack      <= 1'b0;
            x_nack     <= 1'b0;
            o_ack      <= 1'b0;
            o_nack     <= 1'b0;
            core_xoro  <= SIDE_NONE;
            core_row   <= '0;
            core_col   <= '0;
            core_ai_en <= 1'b0;
            turn       <= SIDE_NONE;
            move_cnt   <= '0;
            result     <= SIDE_NONE;
            last_row   <= '0;
            last_col   <= '0;
            x_score    <= '0;
            o_score    <= '0;
            draw_score <= '0;
        end else begin
            x_req_d <= x_req;
            o_req_d <= o_req;
            x_ack   <= x_ack_n;
            x_nack  <= x_nack_n;
            o_ack   <= o_ack_n;
            o_nack  <= o_nack_n;

            if (nxt_state == S_CLEAR) begin
                ai_x_q   <= ai_x;
                ai_o_q   <= ai_o;
                turn     <= SIDE_NONE;
                move_cnt <= '0;
                result   <= SIDE_NONE;
            end
            if (state == S_CLEAR) turn <= SIDE_X;

            if (issue) begin
                core_xoro  <= turn;
                core_ai_en <= ai_turn;
                core_row   <= ai_turn ? 2'd0 : (turn == SIDE_X ? x_row : o_row);
                core_col   <= ai_turn ? 2'd0 : (turn == SIDE_X ? x_col : o_col);
                lat_cnt    <= '0;
            end
            if (state == S_RESP && !resp_done) lat_cnt <= lat_cnt + 2'd1;

            if (resp_done && !core_err) begin
                move_cnt <= move_cnt + 4'd1;
                last_row <= core_rowout;
                last_col <= core_colout;
                if (!end_game) turn <= opp;
            end

            if (end_game) begin
                result <= award;
                turn   <= SIDE_NONE;
                if (award == SIDE_X && x_score != SCORE_MAX) x_score <= x_score + 1'b1;
                if (award == SIDE_O && o_score != SCORE_MAX) o_score <= o_score + 1'b1;
                if (award == RES_DRAW && draw_score != SCORE_MAX) draw_score <= draw_score + 1'b1;
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // Held at zero outside WAIT so each entry to WAIT starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state != S_WAIT) to_cnt <= '0;
            else if (!ai_turn)   to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = state == S_WAIT && !new_game && !issue && !ai_turn
                         && to_cnt == TO_W'(TIMEOUT_CYC - 1);
    assign timeout     = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: doc/tictactoe_turn_ctrl.md
Name: tictactoe_turn_ctrl

Overview:
Game sequencer in front of the tictactoe core. Enforces X/O turn order and arbitrates the two player move ports. Launches AI moves through core ai_en, and tracks move count, win/draw and saturating score counters. The core remains the only holder of board state; this block only issues moves and interprets core responses.

Parameters:
CORE_LAT, 1, cycles from core_go to valid core_err/core_win/core_*out (legal 1..3)
SCORE_W, 4, width of each score counter
TIMEOUT_CYC, 1000, idle cycles allowed for an on-turn human (used only with TURN_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
new_game  in  1  start/restart request, level sampled per cycle
ai_x, ai_o  in  1 each  side played by core AI; sampled when new_game is accepted
x_req, o_req  in  1 each  move request; acted on at rising edge only
x_row, x_col, o_row, o_col  in  2 each  requested cell, 0..2
x_ack, x_nack, o_ack, o_nack  out  1 each  1-cycle result pulses
core_clr  out  1  1-cycle active-high clear to core reset
core_go  out  1  1-cycle move strobe; core_xoro/row/col/ai_en stable while high
core_xoro  out  2  01=X, 10=O
core_row, core_col  out  2 each  move cell (0 when core_ai_en=1)
core_ai_en  out  1  core chooses the move
core_err  in  1  core rejected move (occupied cell / AI none)
core_win  in  2  00 none, 01 X, 10 O
core_rowout, core_colout  in  2 each  cell actually played (AI echo)
turn  out  2  01 X, 10 O, 00 not playing
move_cnt  out  4  accepted moves this game, 0..9
game_over  out  1  game finished
result  out  2  00 none, 01 X, 10 O, 11 draw
last_row, last_col  out  2 each  most recently accepted cell
x_score, o_score, draw_score  out  SCORE_W each  saturating counters
timeout  out  1  forfeit pulse; tied 0 without the feature

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; every output 0; scores 0. Scores clear only on reset.
- States: IDLE, CLEAR, WAIT, ISSUE, RESP, GAME_OVER.
- new_game: honoured in IDLE, WAIT and GAME_OVER; ignored in CLEAR, ISSUE and RESP.
  - Action: go to CLEAR; core_clr=1 for that one cycle; latch ai_x/ai_o.
  - Next cycle: WAIT with turn=01, move_cnt=0, result=00, game_over=0.
  - Abandoning a game from WAIT changes no score.
- WAIT, human side on turn: a rising edge on the on-turn req with row and col ≤2 moves to ISSUE.
  - row or col = 3: nack next cycle; no core_go.
- WAIT, AI side on turn: go to ISSUE directly with core_ai_en=1.
- ISSUE: one cycle; core_go=1 and core_xoro=turn; then RESP.
- RESP: counts CORE_LAT cycles, samples core outputs on the last one. Outputs update on the following cycle:
  - core_err=1, human move: nack; turn and move_cnt unchanged; back to WAIT.
  - core_err=1, AI move: AI forfeits; result = opponent; opponent score +1; GAME_OVER.
  - core_err=0: ack pulse (none for AI); move_cnt+1; last_row/col = core_rowout/colout.
    - core_win≠00: result=core_win; matching score +1; GAME_OVER.
    - else move_cnt reaches 9: result=11; draw_score +1; GAME_OVER.
    - else turn toggles; back to WAIT.
- Latency for a human move with req edge seen at edge t: core_go during cycle t+1; ack visible in cycle t+2+CORE_LAT.
- Off-turn request, or any request in IDLE/CLEAR/GAME_OVER: nack the next cycle, in any state, without disturbing an in-flight move.
- Simultaneous x_req and o_req edges: only the on-turn one is served; the other is nacked.
- Requests from a side configured as AI are always nacked.
- GAME_OVER: game_over=1, turn=00, result held until the next CLEAR.
- Scores saturate at 2^SCORE_W−1.
- reset asserted mid-move: the in-flight move is dropped with no ack/nack; the block returns to the reset values.

Optional Feature:
TURN_TIMEOUT_EN
- Defined:
  - A counter runs while in WAIT with a human side on turn; it restarts on every entry to WAIT.
  - The counter reaching TIMEOUT_CYC forfeits that side: timeout=1 for one cycle; result = opponent; opponent score +1; GAME_OVER.
  - AI turns are never timed.
- Not defined:
  - No counter logic.
  - timeout tied 0.
  - WAIT holds indefinitely.

Test Plan:
1. Basic human move: reset low 2 cycles, new_game, x_req edge with (1,1), core_err=0, core_win=00, CORE_LAT=1 → core_go with xoro=01, row=1, col=1 at t+1; x_ack at t+3; turn=10; move_cnt=1; last_row/col=1/1.
2. Rejections:
   - o_req edge while turn=01 → o_nack 1 cycle, no core_go.
   - x_req with row=3 → x_nack, no core_go.
   - Legal cell with core_err=1 → x_nack, move_cnt unchanged, turn=01.
3. X win: core_win=01 on the 5th accepted move → result=01, game_over=1, x_score=1, turn=00; later x_req → x_nack.
4. Draw and self-play:
   - 9 accepted moves with core_win=00 → result=11, draw_score=1.
   - ai_x=ai_o=1 → self-play ends with core_ai_en=1 on all core_go and no ack pulses.
5. Saturation and mid-game reset:
   - SCORE_W=2, four X wins → x_score stays 3.
   - new_game in WAIT mid-game → core_clr pulse, scores unchanged.
   - reset low during RESP → all outputs 0, no ack.
6. Timeout: TURN_TIMEOUT_EN, TIMEOUT_CYC=10, X idle in WAIT → timeout pulse after 10 cycles, result=10, o_score=1.
